// File: rtl/mdu_hilo.sv
// Multiply/divide unit holding the MIPS HI/LO registers: single-cycle MULT/MULTU/MTHI/MTLO,
// 32-step restoring divider for DIV/DIVU. Optional macro MDU_EARLY_OUT_EN: finish |rs| < |rt| divides at accept.
module mdu_hilo #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        op_ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi, r_lo;
    logic          r_dbz;
    logic [31:0]   r_quo, r_rem, r_dvs;
    logic          r_neg_q, r_neg_r;

    logic [63:0] w_mul_s, w_mul_u;
    logic        w_signed;
    logic [31:0] w_rs_abs, w_rt_abs, w_dvd, w_dvs;
    logic        w_early;
    logic [32:0] w_shift, w_diff;
    logic [31:0] w_quo_fix, w_rem_fix;

    assign w_mul_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign w_mul_u = {32'b0, rs_data} * {32'b0, rt_data};

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign w_signed = (op == OP_DIV);
    assign w_rs_abs = rs_data[31] ? -rs_data : rs_data;
    assign w_rt_abs = rt_data[31] ? -rt_data : rt_data;
    assign w_dvd    = w_signed ? w_rs_abs : rs_data;
    assign w_dvs    = w_signed ? w_rt_abs : rt_data;

`ifdef MDU_EARLY_OUT_EN
    assign w_early = (w_dvd < w_dvs);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (clk_enable) begin
            r_dbz <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT:  {r_hi, r_lo} <= w_mul_s;
                            OP_MULTU: {r_hi, r_lo} <= w_mul_u;
                            OP_MTHI:  r_hi <= rs_data;
                            OP_MTLO:  r_lo <= rs_data;
                            OP_DIV, OP_DIVU: begin
                                if (rt_data == 32'd0) begin
                                    r_hi  <= rs_data;
                                    r_lo  <= 32'hFFFF_FFFF;
                                    r_dbz <= 1'b1;
                                end else if (w_early) begin
                                    r_hi <= rs_data;
                                    r_lo <= 32'd0;
                                end else begin
                                    r_quo   <= w_dvd;
                                    r_rem   <= 32'd0;
                                    r_dvs   <= w_dvs;
                                    r_neg_q <= w_signed & (rs_data[31] ^ rt_data[31]);
                                    r_neg_r <= w_signed & rs_data[31];
                                    r_cnt   <= '0;
                                    r_state <= S_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (!w_diff[32]) begin
                        r_rem <= w_diff[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_rem_fix;
                    r_lo    <= w_quo_fix;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign op_ready    = !busy;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random ops against an arithmetic HI/LO model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        op_ready, busy, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_hilo #(.DIV_ITERS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .op_valid    (op_valid),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .op_ready    (op_ready),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint mag(input logic [31:0] v, input bit sgn);
        longint s;
        s = sgn ? longint'($signed(v)) : longint'({32'b0, v});
        return (s < 0) ? -s : s;
    endfunction

    // Architectural result of one op; also returns the expected number of busy cycles.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        lat = 0;
        case (o)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
                {hi_m, lo_m} = p;
            end
            3'd2: begin
                p = {32'b0, a} * {32'b0, b};
                {hi_m, lo_m} = p;
            end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    hi_m = a;
                    lo_m = 32'hFFFF_FFFF;
                end else begin
                    sa = (o == 3'd3) ? longint'($signed(a)) : longint'({32'b0, a});
                    sb = (o == 3'd3) ? longint'($signed(b)) : longint'({32'b0, b});
                    q = sa / sb;
                    r = sa % sb;
                    lo_m = q[31:0];
                    hi_m = r[31:0];
                    lat = 33;
`ifdef MDU_EARLY_OUT_EN
                    if (mag(a, o == 3'd3) < mag(b, o == 3'd3)) lat = 0;
`endif
                end
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        op_valid = 1'b0;
        op = 3'd0;
    endtask

    // Issue one op, optionally with a 5-cycle enable gap and an MTHI attempt while busy, then check it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int gap_at, input int mthi_at);
        int lat, n;
        logic [31:0] old_hi, old_lo;
        old_hi = hi_m;
        old_lo = lo_m;
        model(o, a, b, lat);
        issue(o, a, b);
        if ((o == 3'd3 || o == 3'd4) && b == 32'd0) begin
            check({tag, " dbz"}, 64'(div_by_zero), 64'd1);
            check({tag, " busy"}, 64'(busy), 64'd0);
            check({tag, " hi"}, 64'(hi), 64'(hi_m));
            check({tag, " lo"}, 64'(lo), 64'(lo_m));
            @(negedge clk);
            check({tag, " dbz_end"}, 64'(div_by_zero), 64'd0);
        end else begin
            n = 0;
            while (busy && n < 200) begin
                if (n == gap_at) clk_enable = 1'b0;
                if (gap_at >= 0 && n == gap_at + 5) clk_enable = 1'b1;
                if (n == mthi_at) begin
                    op_valid = 1'b1;
                    op = 3'd5;
                    rs_data = 32'hDEAD_BEEF;
                end else if (n == mthi_at + 1) begin
                    op_valid = 1'b0;
                    op = 3'd0;
                end
                if (n == 16) begin
                    check({tag, " hold_hi"}, 64'(hi), 64'(old_hi));
                    check({tag, " hold_lo"}, 64'(lo), 64'(old_lo));
                    check({tag, " ready"}, 64'(op_ready), 64'd0);
                end
                n++;
                @(negedge clk);
            end
            clk_enable = 1'b1;
            op_valid = 1'b0;
            check({tag, " latency"}, 64'(n), 64'(lat + ((gap_at >= 0) ? 5 : 0)));
            check({tag, " hi"}, 64'(hi), 64'(hi_m));
            check({tag, " lo"}, 64'(lo), 64'(lo_m));
            check({tag, " ready"}, 64'(op_ready), 64'd1);
        end
    endtask

    initial begin
        int n, sel;
        logic [2:0] o;
        logic [31:0] a, b;

        reset = 1'b1;
        clk_enable = 1'b1;
        op_valid = 1'b0;
        op = 3'd0;
        rs_data = 32'h55;
        rt_data = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = ~op_valid;
            op = (i % 2 == 0) ? 3'd5 : 3'd4;
        end
        @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset ready", 64'(op_ready), 64'd1);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;
        op_valid = 1'b0;
        op = 3'd0;
        @(negedge clk);
        check("post-reset hi", 64'(hi), 64'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, -1, -1);
        check("mult hi const", 64'(hi), 64'hFFFF_FFFF);
        check("mult lo const", 64'(lo), 64'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, -1, -1);
        check("multu hi const", 64'(hi), 64'h2);
        run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, -1, 20);
        check("div lo const", 64'(lo), 64'hFFFF_FFFD);
        check("div hi const", 64'(hi), 64'hFFFF_FFFF);
        run_op("div_gap", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, -1);
        run_op("divu_zero", 3'd4, 32'h1234, 32'd0, -1, -1);
        run_op("div_wrap", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        check("div_wrap lo const", 64'(lo), 64'h8000_0000);
        run_op("divu_5_9", 3'd4, 32'd5, 32'd9, -1, -1);
        run_op("div_neg_small", 3'd3, 32'hFFFF_FFFD, 32'd9, -1, -1);

        issue(3'd4, 32'd100, 32'd7);
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        run_op("mtlo_after_abort", 3'd6, 32'hAA, 32'd0, -1, -1);

        for (int i = 0; i < 60; i++) begin
            o = 3'(1 + ($urandom % 6));
            a = $urandom;
            sel = $urandom % 4;
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                default: begin
                    a = $urandom_range(0, 99);
                    b = $urandom;
                end
            endcase
            run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
